// File: rtl/serdesphy_link_ctrl.sv
// serdesphy_link_ctrl: link bring-up sequencer for the SerDes PHY.
//   Powers up the PLL, enables the TX/RX paths, runs a PRBS qualification
//   window, and declares the link up once CDR lock and the PRBS error count
//   qualify. A failed attempt retries up to MAX_RETRY times, after which a
//   sticky failure is held until the CSR enable is removed.
//
// Ports:
//   clk_ref_24m_i   24 MHz reference clock (only clock)
//   rst_i           synchronous active-high reset
//   en_i            CSR link enable (synchronous)
//   pll_lock_i      PLL lock (asynchronous, synchronized here)
//   cdr_lock_i      CDR lock (asynchronous, synchronized here)
//   prbs_err_i      single-cycle PRBS error pulse (synchronous)
//   pll_en_o        PLL enable
//   tx_en_o         TX serializer/driver enable
//   rx_en_o         RX/CDR enable
//   prbs_gen_en_o   TX PRBS generator enable
//   prbs_chk_en_o   RX PRBS checker enable
//   link_up_o       link qualified
//   link_fail_o     retries exhausted (sticky until en_i=0)
//   state_o         current state encoding
//   retry_cnt_o     retries taken since IDLE
//   err_cnt_o       PRBS errors in current/last window (saturating)
module serdesphy_link_ctrl #(
  parameter int unsigned PLL_TIMEOUT = 4096,
  parameter int unsigned CDR_TIMEOUT = 2048,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned CHECK_LEN   = 256,
  parameter int unsigned MAX_ERR     = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_ref_24m_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       pll_lock_i,
  input  logic       cdr_lock_i,
  input  logic       prbs_err_i,
  output logic       pll_en_o,
  output logic       tx_en_o,
  output logic       rx_en_o,
  output logic       prbs_gen_en_o,
  output logic       prbs_chk_en_o,
  output logic       link_up_o,
  output logic       link_fail_o,
  output logic [2:0] state_o,
  output logic [2:0] retry_cnt_o,
  output logic [7:0] err_cnt_o
);

  localparam int unsigned MAX_A   = (PLL_TIMEOUT > CDR_TIMEOUT) ? PLL_TIMEOUT : CDR_TIMEOUT;
  localparam int unsigned MAX_B   = (SETTLE > CHECK_LEN) ? SETTLE : CHECK_LEN;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_TIMEOUT - 1);
  localparam logic [CW-1:0] CDR_LAST    = CW'(CDR_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ALL     = {CW{1'b1}};
  localparam logic [8:0]    ERR_LIMIT   = 9'(MAX_ERR);
  localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLL_WAIT   = 3'd1,
    ST_TX_SETTLE  = 3'd2,
    ST_CDR_WAIT   = 3'd3,
    ST_PRBS_CHECK = 3'd4,
    ST_LINK_UP    = 3'd5,
    ST_RETRY      = 3'd6,
    ST_FAIL       = 3'd7
  } state_e;

  // Output bundle order: {pll, tx, rx, prbs_gen, prbs_chk, link_up, link_fail}
  function automatic logic [6:0] decode_outs(input state_e s);
    logic [6:0] v;
    v = 7'b000_0000;
    case (s)
      ST_PLL_WAIT:   v = 7'b100_0000;
      ST_TX_SETTLE:  v = 7'b111_1000;
      ST_CDR_WAIT:   v = 7'b111_1000;
      ST_PRBS_CHECK: v = 7'b111_1100;
      ST_LINK_UP:    v = 7'b111_0010;
      ST_FAIL:       v = 7'b000_0001;
      default:       v = 7'b000_0000;
    endcase
    return v;
  endfunction

  logic          pll_meta_q, pll_s_q, cdr_meta_q, cdr_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic [7:0]    err_q, err_d;
  logic [6:0]    outs_q, outs_d;
  logic [8:0]    err_sum_s;
  logic [7:0]    err_sat_s;

  // Errors seen so far in the window including this cycle's pulse.
  assign err_sum_s = {1'b0, err_q} + {8'd0, prbs_err_i};
  assign err_sat_s = (err_q == 8'hFF) ? 8'hFF : err_sum_s[7:0];

  // Next-state selection; disabling the link overrides every other event.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PLL_WAIT;
        end
        ST_PLL_WAIT: begin
          if (pll_s_q) begin
            state_d = ST_TX_SETTLE;
          end else if (cnt_q == PLL_LAST) begin
            state_d = ST_RETRY;
          end else begin
            state_d = ST_PLL_WAIT;
          end
        end
        ST_TX_SETTLE: begin
          if (!pll_s_q) begin
            state_d = ST_RETRY;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_CDR_WAIT;
          end else begin
            state_d = ST_TX_SETTLE;
          end
        end
        ST_CDR_WAIT: begin
          if (!pll_s_q) begin
            state_d = ST_RETRY;
          end else if (cdr_s_q) begin
            state_d = ST_PRBS_CHECK;
          end else if (cnt_q == CDR_LAST) begin
            state_d = ST_RETRY;
          end else begin
            state_d = ST_CDR_WAIT;
          end
        end
        ST_PRBS_CHECK: begin
          if (!pll_s_q || !cdr_s_q || (err_sum_s >= ERR_LIMIT)) begin
            state_d = ST_RETRY;
          end else if (cnt_q == CHECK_LAST) begin
            state_d = ST_LINK_UP;
          end else begin
            state_d = ST_PRBS_CHECK;
          end
        end
        ST_LINK_UP: begin
          if (!pll_s_q || !cdr_s_q) begin
            state_d = ST_RETRY;
          end else begin
            state_d = ST_LINK_UP;
          end
        end
        ST_RETRY: begin
          if (cnt_q == SETTLE_LAST) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_WAIT;
            end
          end else begin
            state_d = ST_RETRY;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Cycle counter, retry counter and PRBS error counter updates.
  always_comb begin
    cnt_d   = cnt_q;
    retry_d = retry_q;
    err_d   = err_q;
    outs_d  = decode_outs(state_d);

    // Saturate rather than wrap while parked in untimed states.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_ALL) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (state_d == ST_IDLE) begin
      retry_d = 3'd0;
    end else if ((state_d == ST_RETRY) && (state_q != ST_RETRY)) begin
      retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
    end else begin
      retry_d = retry_q;
    end

    // The window's last pulse is kept so LINK_UP/RETRY report it.
    if (state_d == ST_IDLE) begin
      err_d = 8'd0;
    end else if (state_q == ST_PRBS_CHECK) begin
      err_d = err_sat_s;
    end else if (state_d == ST_PRBS_CHECK) begin
      err_d = 8'd0;
    end else begin
      err_d = err_q;
    end
  end

  // Lock synchronizers, state register and registered outputs.
  always_ff @(posedge clk_ref_24m_i) begin
    if (rst_i) begin
      pll_meta_q <= 1'b0;
      pll_s_q    <= 1'b0;
      cdr_meta_q <= 1'b0;
      cdr_s_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= 3'd0;
      err_q      <= 8'd0;
      outs_q     <= 7'd0;
    end else begin
      pll_meta_q <= pll_lock_i;
      pll_s_q    <= pll_meta_q;
      cdr_meta_q <= cdr_lock_i;
      cdr_s_q    <= cdr_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      outs_q     <= outs_d;
    end
  end

  assign {pll_en_o, tx_en_o, rx_en_o, prbs_gen_en_o,
          prbs_chk_en_o, link_up_o, link_fail_o} = outs_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// tb_serdesphy_link_ctrl: self-checking bench for serdesphy_link_ctrl using
// small timing parameters and randomized lock/error timing. Expected values
// come from the state-sequence timing rules (latencies, window lengths,
// error thresholds) computed with plain arithmetic.
module tb_serdesphy_link_ctrl;

  localparam int PLL_TO = 64;
  localparam int CDR_TO = 32;
  localparam int SET    = 4;
  localparam int CHK    = 16;
  localparam int MERR   = 2;
  localparam int MRET   = 3;

  logic       clk = 1'b0;
  logic       rst, en, pll_lock, cdr_lock, prbs_err;
  logic       pll_en, tx_en, rx_en, gen_en, chk_en, link_up, link_fail;
  logic [2:0] state, retry_cnt;
  logic [7:0] err_cnt;
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  assign outs = {pll_en, tx_en, rx_en, gen_en, chk_en, link_up, link_fail};

  serdesphy_link_ctrl #(
    .PLL_TIMEOUT(PLL_TO), .CDR_TIMEOUT(CDR_TO), .SETTLE(SET),
    .CHECK_LEN(CHK), .MAX_ERR(MERR), .MAX_RETRY(MRET)
  ) dut (
    .clk_ref_24m_i(clk), .rst_i(rst), .en_i(en),
    .pll_lock_i(pll_lock), .cdr_lock_i(cdr_lock), .prbs_err_i(prbs_err),
    .pll_en_o(pll_en), .tx_en_o(tx_en), .rx_en_o(rx_en),
    .prbs_gen_en_o(gen_en), .prbs_chk_en_o(chk_en),
    .link_up_o(link_up), .link_fail_o(link_fail),
    .state_o(state), .retry_cnt_o(retry_cnt), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Enable table: {pll, tx, rx, gen, chk, link_up, link_fail} per state.
  function automatic logic [6:0] exp_out(input int st);
    case (st)
      1:       return 7'b100_0000;
      2, 3:    return 7'b111_1000;
      4:       return 7'b111_1100;
      5:       return 7'b111_0010;
      7:       return 7'b000_0001;
      default: return 7'b000_0000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pll_lock = 1'b0; cdr_lock = 1'b0; prbs_err = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Steps until state equals target or budget expires; caller checks state.
  task automatic wait_state(input int target, input int budget, output int cycles);
    cycles = 0;
    while ((int'(state) != target) && (cycles < budget)) begin
      step(1);
      cycles++;
    end
  endtask

  // Locks already synchronized, then enable: reaches PRBS_CHECK quickly.
  task automatic bring_to_check();
    int c;
    do_reset();
    pll_lock = 1'b1; cdr_lock = 1'b1;
    step(3);
    en = 1'b1;
    wait_state(4, 40, c);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pll_lock = 1'b1; cdr_lock = 1'b1; prbs_err = 1'b1;
    step(3);
    total++;
    if ({state, retry_cnt, err_cnt, outs} !== 21'd0) begin
      bad++;
      $display("FAIL reset_values: state=%0d retry=%0d err=%0d outs=%b expected all 0",
               state, retry_cnt, err_cnt, outs);
    end
    do_reset();
    total++;
    if ({state, outs} !== 10'd0) begin
      bad++;
      $display("FAIL reset_idle: state=%0d outs=%b expected 0/0", state, outs);
    end
  endtask

  task automatic test_nominal(input int a, input int b);
    int first [8];
    int out_err;
    int e2, e3, e4, e5;
    for (int i = 0; i < 8; i++) first[i] = -1;
    out_err = 0;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (first[state] < 0) first[state] = k;
      if (outs !== exp_out(int'(state))) out_err++;
      if (k == a) pll_lock = 1'b1;
      if (k == b) cdr_lock = 1'b1;
      if (state == 3'd5) break;
    end
    e2 = a + 3;
    e3 = a + 3 + SET;
    e4 = ((a + 4 + SET) > (b + 3)) ? (a + 4 + SET) : (b + 3);
    e5 = e4 + CHK;
    total++;
    if (first[1] != 1 || first[2] != e2 || first[3] != e3 || first[4] != e4 || first[5] != e5) begin
      bad++;
      $display("FAIL nominal_seq a=%0d b=%0d: entries 1/2/3/4/5 at %0d/%0d/%0d/%0d/%0d expected 1/%0d/%0d/%0d/%0d",
               a, b, first[1], first[2], first[3], first[4], first[5], e2, e3, e4, e5);
    end
    total++;
    if (first[6] != -1 || first[7] != -1 || out_err != 0) begin
      bad++;
      $display("FAIL nominal_outs: retry_seen=%0d fail_seen=%0d output_errors=%0d expected -1/-1/0",
               first[6], first[7], out_err);
    end
    total++;
    if (link_up !== 1'b1 || err_cnt !== 8'd0 || retry_cnt !== 3'd0) begin
      bad++;
      $display("FAIL nominal_final: link_up=%b err=%0d retry=%0d expected 1/0/0",
               link_up, err_cnt, retry_cnt);
    end
  endtask

  task automatic test_pll_timeout();
    int k;
    do_reset();
    en = 1'b1;
    wait_state(7, 300, k);
    total++;
    if (k != 1 + MRET * (PLL_TO + SET)) begin
      bad++;
      $display("FAIL pll_timeout_time: reached FAIL after %0d cycles expected %0d",
               k, 1 + MRET * (PLL_TO + SET));
    end
    total++;
    if (state !== 3'd7 || outs !== exp_out(7) || retry_cnt !== 3'(MRET)) begin
      bad++;
      $display("FAIL pll_timeout_fail: state=%0d outs=%b retry=%0d expected 7/0000001/%0d",
               state, outs, retry_cnt, MRET);
    end
    step(5);
    total++;
    if (state !== 3'd7 || link_fail !== 1'b1) begin
      bad++;
      $display("FAIL fail_sticky: state=%0d link_fail=%b expected 7/1", state, link_fail);
    end
    en = 1'b0;
    step(1);
    total++;
    if (state !== 3'd0 || retry_cnt !== 3'd0 || outs !== 7'd0) begin
      bad++;
      $display("FAIL fail_clear: state=%0d retry=%0d outs=%b expected 0/0/0", state, retry_cnt, outs);
    end
  endtask

  // Runs one PRBS window with errors on the cycles set in mask.
  task automatic test_prbs_window(input logic [15:0] mask, input string name);
    int n, fail_w, pop, exit_w, exp_w, exp_st, exp_err;
    logic [2:0] exit_st, exit_retry;
    logic [7:0] exit_err;
    n = 0; fail_w = -1; pop = 0;
    for (int w = 0; w < CHK; w++) begin
      if (mask[w]) begin
        n++;
        if (fail_w < 0) pop++;
      end
      if (n >= MERR && fail_w < 0) fail_w = w;
    end
    exp_w   = (fail_w >= 0) ? fail_w : CHK - 1;
    exp_st  = (fail_w >= 0) ? 6 : 5;
    exp_err = (fail_w >= 0) ? MERR : pop;
    bring_to_check();
    exit_w = -1; exit_st = 3'd0; exit_err = 8'd0; exit_retry = 3'd0;
    for (int w = 0; w < CHK + 2; w++) begin
      prbs_err = (w < CHK) ? mask[w] : 1'b0;
      step(1);
      if (state !== 3'd4) begin
        exit_w = w; exit_st = state; exit_err = err_cnt; exit_retry = retry_cnt;
        break;
      end
    end
    prbs_err = 1'b0;
    total++;
    if (exit_w != exp_w || int'(exit_st) != exp_st || int'(exit_err) != exp_err ||
        int'(exit_retry) != ((exp_st == 6) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s mask=%h: left window at %0d to %0d err=%0d retry=%0d expected %0d/%0d/%0d/%0d",
               name, mask, exit_w, exit_st, exit_err, exit_retry, exp_w, exp_st, exp_err,
               (exp_st == 6) ? 1 : 0);
    end
  endtask

  task automatic test_prbs_errors();
    int c;
    logic [15:0] m;
    m = 16'd0;
    m[$urandom_range(0, 4)] = 1'b1;
    m[5] = 1'b1;
    test_prbs_window(m, "prbs_two_errors");
    wait_state(5, 60, c);
    total++;
    if (state !== 3'd5 || err_cnt !== 8'd0 || retry_cnt !== 3'd1) begin
      bad++;
      $display("FAIL prbs_second_attempt: state=%0d err=%0d retry=%0d expected 5/0/1",
               state, err_cnt, retry_cnt);
    end
    test_prbs_window(16'h8000, "prbs_last_cycle");
    for (int i = 0; i < 6; i++) begin
      prbs_err = 1'($urandom_range(0, 1));
      step(1);
    end
    prbs_err = 1'b0;
    step(1);
    total++;
    if (state !== 3'd5 || err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL linkup_ignores_err: state=%0d err=%0d expected 5/1", state, err_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      m = 16'($urandom & $urandom & $urandom);
      test_prbs_window(m, "prbs_random");
    end
  endtask

  task automatic test_cdr_drop();
    int c;
    bring_to_check();
    wait_state(5, 30, c);
    step(2);
    cdr_lock = 1'b0;
    step(2);
    total++;
    if (state !== 3'd5) begin
      bad++;
      $display("FAIL cdr_drop_early: state=%0d expected 5", state);
    end
    step(1);
    total++;
    if (state !== 3'd6 || link_up !== 1'b0 || retry_cnt !== 3'd1) begin
      bad++;
      $display("FAIL cdr_drop_retry: state=%0d link_up=%b retry=%0d expected 6/0/1",
               state, link_up, retry_cnt);
    end
    cdr_lock = 1'b1;
    wait_state(5, 60, c);
    total++;
    if (state !== 3'd5 || c != SET + 1 + SET + 1 + CHK || retry_cnt !== 3'd1 || link_up !== 1'b1) begin
      bad++;
      $display("FAIL cdr_relock: state=%0d cycles=%0d retry=%0d link_up=%b expected 5/%0d/1/1",
               state, c, retry_cnt, link_up, SET + 2 + SET + CHK);
    end
  endtask

  task automatic test_en_drop_and_rst();
    int c;
    do_reset();
    pll_lock = 1'b1;
    step(3);
    en = 1'b1;
    wait_state(3, 20, c);
    step($urandom_range(1, 10));
    en = 1'b0;
    step(1);
    total++;
    if ({state, retry_cnt, err_cnt, outs} !== 21'd0) begin
      bad++;
      $display("FAIL en_drop: state=%0d retry=%0d err=%0d outs=%b expected all 0",
               state, retry_cnt, err_cnt, outs);
    end
    bring_to_check();
    prbs_err = 1'b1;
    step(1);
    prbs_err = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    total++;
    if ({state, retry_cnt, err_cnt, outs} !== 21'd0) begin
      bad++;
      $display("FAIL rst_mid_check: state=%0d retry=%0d err=%0d outs=%b expected all 0",
               state, retry_cnt, err_cnt, outs);
    end
    rst = 1'b0;
    step(2);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL rst_sync_cleared: state=%0d expected 1", state);
    end
    step(1);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL rst_resync: state=%0d expected 2", state);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pll_lock = 1'b0; cdr_lock = 1'b0; prbs_err = 1'b0;
    test_reset();
    test_nominal(10, 30);
    begin
      int a;
      a = $urandom_range(1, 50);
      test_nominal(a, a + $urandom_range(1, 30));
    end
    test_pll_timeout();
    test_prbs_errors();
    test_cdr_drop();
    test_en_drop_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serdesphy_link_ctrl.md
Name: serdesphy_link_ctrl

Overview:
Link bring-up sequencer for the SerDes PHY. It brings up the PLL, enables the TX/RX paths and runs PRBS training. It then qualifies CDR lock and the PRBS error rate before declaring the link up. It retries failed bring-ups up to a limit, then latches a failure. It sits between the CSR block (enable/status) and the PLL, TX serializer, RX CDR and PRBS gen/check blocks inside serdesphy_top.

Parameters:
PLL_TIMEOUT, 4096, max cycles in PLL_WAIT before retry
CDR_TIMEOUT, 2048, max cycles in CDR_WAIT before retry
SETTLE, 16, cycles in TX_SETTLE and in RETRY (enables off)
CHECK_LEN, 256, PRBS qualification window in cycles
MAX_ERR, 4, PRBS error count that fails qualification (>=)
MAX_RETRY, 3, retries before FAIL (1..7)

Ports:
clk_ref_24m  in  1  24 MHz reference clock, sole clock
rst  in  1  synchronous active-high reset
en  in  1  CSR link enable, synchronous to clk_ref_24m
pll_lock  in  1  PLL lock, asynchronous, 2-FF synchronized internally
cdr_lock  in  1  CDR lock, asynchronous, 2-FF synchronized internally
prbs_err  in  1  single-cycle PRBS error pulse, synchronous
pll_en  out  1  PLL enable
tx_en  out  1  TX serializer/driver enable
rx_en  out  1  RX/CDR enable
prbs_gen_en  out  1  TX PRBS generator enable
prbs_chk_en  out  1  RX PRBS checker enable
link_up  out  1  link qualified
link_fail  out  1  retries exhausted (sticky until en=0)
state  out  3  current state encoding, CSR-visible
retry_cnt  out  3  retries taken since IDLE
err_cnt  out  8  PRBS errors in current/last window, saturating at 255

Behaviour:
- One clock domain; reset is synchronous and active-high (rst sampled on clk_ref_24m). Reset: state=IDLE, all outputs 0, counters 0, synchronizer flops 0.
- Moore outputs: decoded from the state register only. No combinational input->output path.
- Lock inputs: 2-flop synchronizers (pll_s, cdr_s), 2-cycle latency.
- Encodings: IDLE=0, PLL_WAIT=1, TX_SETTLE=2, CDR_WAIT=3, PRBS_CHECK=4, LINK_UP=5, RETRY=6, FAIL=7.
- Enables per state:
  - PLL_WAIT: pll_en.
  - TX_SETTLE, CDR_WAIT: pll_en, tx_en, rx_en, prbs_gen_en.
  - PRBS_CHECK: those four plus prbs_chk_en.
  - LINK_UP: pll_en, tx_en, rx_en, link_up.
  - FAIL: link_fail only.
  - IDLE, RETRY: all enables 0.
- Cycle counter cnt: cleared on every state change, increments each cycle otherwise.
- Transitions (highest priority first):
  1. en=0 in any state -> IDLE next cycle; retry_cnt and err_cnt cleared in IDLE.
  2. IDLE: en=1 -> PLL_WAIT.
  3. PLL_WAIT: pll_s=1 -> TX_SETTLE; else cnt==PLL_TIMEOUT-1 -> RETRY.
  4. TX_SETTLE: pll_s=0 -> RETRY; else cnt==SETTLE-1 -> CDR_WAIT.
  5. CDR_WAIT: pll_s=0 -> RETRY; cdr_s=1 -> PRBS_CHECK; else cnt==CDR_TIMEOUT-1 -> RETRY.
  6. PRBS_CHECK:
     - err_cnt cleared on entry; each prbs_err pulse adds 1.
     - The pulse on the current cycle counts toward the decision in that same cycle.
     - pll_s=0, cdr_s=0, or (err_cnt + prbs_err) >= MAX_ERR -> RETRY.
     - Else cnt==CHECK_LEN-1 -> LINK_UP.
  7. LINK_UP: pll_s=0 or cdr_s=0 -> RETRY. prbs_err is ignored and err_cnt holds its last window value.
  8. RETRY: retry_cnt increments (saturating) on entry. After SETTLE cycles: retry_cnt==MAX_RETRY -> FAIL, else -> PLL_WAIT.
  9. FAIL: held until en=0.
- Simultaneous events: lock loss and timeout in the same cycle -> RETRY, counted as one retry. prbs_err outside PRBS_CHECK is ignored.
- rst mid-operation: returns to the reset values on the next edge, regardless of state.

Test Plan:
Bench parameters for all scenarios: PLL_TIMEOUT=64, CDR_TIMEOUT=32, SETTLE=4, CHECK_LEN=16, MAX_ERR=2, MAX_RETRY=3.
1. Nominal bring-up: en=1, pll_lock=1 at cycle 10, cdr_lock=1 at cycle 30, no errors -> state sequence 0,1,2,3,4,5. link_up rises exactly 16 cycles after state=4; err_cnt=0, retry_cnt=0.
2. pll_lock held 0 -> three PLL_WAIT timeouts of 64 cycles, each followed by 4 cycles of RETRY -> state=7, link_fail=1, retry_cnt=3, all enables 0. Then en=0 -> state=0, retry_cnt=0 next cycle.
3. Two prbs_err pulses in PRBS_CHECK, second on window cycle 5 -> state=6 on the next edge, retry_cnt=1, err_cnt=2. Clean second attempt -> LINK_UP with err_cnt=0.
4. One prbs_err pulse, on the last window cycle -> LINK_UP reached, err_cnt=1.
5. In LINK_UP, drop cdr_lock -> link_up=0 and state=6 exactly 3 cycles later. Re-raise cdr_lock -> relock and LINK_UP, retry_cnt=1.
6. en=0 mid CDR_WAIT -> state=0 and all outputs 0 next cycle. Separately, rst=1 mid PRBS_CHECK -> all outputs 0 and synchronizers cleared next cycle.
